// File: rtl/snitch_ro_cache_ctrl.sv
// Control sequencer for the snitch read-only cache: drains cache reads, applies rule/enable config, runs flushes.
// Define SNITCH_RO_CACHE_CTRL_STATS_EN to add flush_cnt_o / drain_cyc_o statistics counters.
module snitch_ro_cache_ctrl #(
  parameter int unsigned NrReq        = 4,
  parameter int unsigned NrAddrRules  = 1,
  parameter int unsigned AxiAddrWidth = 48,
  parameter int unsigned MaxTrans     = 8,
  parameter bit          EnableRst    = 1'b0,
  localparam int unsigned RuleW = (NrAddrRules > 1) ? $clog2(NrAddrRules) : 1,
  localparam int unsigned CntW  = $clog2(MaxTrans + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NrReq-1:0]                    flush_req_i,
  output logic [NrReq-1:0]                    flush_ack_o,
  input  logic                                cfg_valid_i,
  output logic                                cfg_ready_o,
  input  logic [RuleW-1:0]                    cfg_rule_i,
  input  logic [AxiAddrWidth-1:0]             cfg_start_i,
  input  logic [AxiAddrWidth-1:0]             cfg_end_i,
  input  logic                                cfg_enable_i,
  input  logic                                cfg_flush_i,
  input  logic                                cache_ar_hs_i,
  input  logic                                cache_rlast_hs_i,
  output logic                                enable_o,
  output logic [NrAddrRules*AxiAddrWidth-1:0] start_addr_o,
  output logic [NrAddrRules*AxiAddrWidth-1:0] end_addr_o,
  output logic                                flush_valid_o,
  input  logic                                flush_ready_i,
  output logic                                busy_o
`ifdef SNITCH_RO_CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]                         flush_cnt_o,
  output logic [31:0]                         drain_cyc_o
`endif
);

  typedef enum logic [2:0] {Idle, Drain, Apply, Flush, Done} state_e;

  state_e                              state_q;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [NrReq-1:0]                    pending_q, pending_d, ack_q;
  logic                                cfg_pend_q, cfg_enable_q, cfg_flush_q;
  logic [RuleW-1:0]                    cfg_rule_q;
  logic [AxiAddrWidth-1:0]             cfg_start_q, cfg_end_q;
  logic                                en_reg_q, enable_q, cfg_ready_q, flush_valid_q, busy_q;
  logic [NrAddrRules*AxiAddrWidth-1:0] start_q, end_q;

  // Outstanding cache-path reads; saturates at the protocol limits.
  always_comb begin
    cnt_d = cnt_q;
    if (cache_ar_hs_i && !cache_rlast_hs_i && cnt_q != CntW'(MaxTrans)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (cache_rlast_hs_i && !cache_ar_hs_i && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Requests only join the current round while it has not yet started applying/flushing.
  always_comb begin
    pending_d = pending_q;
    if (state_q == Idle || state_q == Drain) begin
      pending_d = pending_q | (flush_req_i & ~ack_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= Idle;
      cnt_q         <= '0;
      pending_q     <= '0;
      ack_q         <= '0;
      cfg_pend_q    <= 1'b0;
      cfg_enable_q  <= 1'b0;
      cfg_flush_q   <= 1'b0;
      cfg_rule_q    <= '0;
      cfg_start_q   <= '0;
      cfg_end_q     <= '0;
      en_reg_q      <= EnableRst;
      enable_q      <= EnableRst;
      cfg_ready_q   <= 1'b0;
      flush_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      start_q       <= '0;
      end_q         <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      cfg_ready_q <= 1'b0;
      ack_q       <= '0;
      case (state_q)
        Idle: begin
          enable_q <= en_reg_q;
          if (|flush_req_i || cfg_valid_i) begin
            state_q  <= Drain;
            busy_q   <= 1'b1;
            enable_q <= 1'b0;
            if (cfg_valid_i) begin
              cfg_pend_q   <= 1'b1;
              cfg_rule_q   <= cfg_rule_i;
              cfg_start_q  <= cfg_start_i;
              cfg_end_q    <= cfg_end_i;
              cfg_enable_q <= cfg_enable_i;
              cfg_flush_q  <= cfg_flush_i;
            end
          end
        end
        Drain: begin
          if (cnt_d == '0) begin
            if (cfg_pend_q) begin
              state_q     <= Apply;
              cfg_ready_q <= 1'b1;
            end else begin
              state_q       <= Flush;
              flush_valid_q <= 1'b1;
            end
          end
        end
        Apply: begin
          // Out-of-range rule indices match no iteration and leave all rules untouched.
          for (int unsigned r = 0; r < NrAddrRules; r++) begin
            if (32'(cfg_rule_q) == r) begin
              start_q[r*AxiAddrWidth +: AxiAddrWidth] <= cfg_start_q;
              end_q[r*AxiAddrWidth +: AxiAddrWidth]   <= cfg_end_q;
            end
          end
          en_reg_q <= cfg_enable_q;
          if (|pending_q || cfg_flush_q) begin
            state_q       <= Flush;
            flush_valid_q <= 1'b1;
          end else begin
            state_q <= Done;
            ack_q   <= pending_q;
          end
        end
        Flush: begin
          if (flush_ready_i) begin
            state_q       <= Done;
            flush_valid_q <= 1'b0;
            ack_q         <= pending_q;
          end
        end
        Done: begin
          state_q    <= Idle;
          busy_q     <= 1'b0;
          pending_q  <= '0;
          cfg_pend_q <= 1'b0;
          enable_q   <= en_reg_q;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign flush_ack_o   = ack_q;
  assign cfg_ready_o   = cfg_ready_q;
  assign enable_o      = enable_q;
  assign start_addr_o  = start_q;
  assign end_addr_o    = end_q;
  assign flush_valid_o = flush_valid_q;
  assign busy_o        = busy_q;

  ar_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cache_ar_hs_i && !cache_rlast_hs_i && cnt_q == CntW'(MaxTrans)));
  rlast_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(cache_rlast_hs_i && !cache_ar_hs_i && cnt_q == '0));

`ifdef SNITCH_RO_CACHE_CTRL_STATS_EN
  logic [31:0] flush_cnt_q, drain_cyc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_q <= '0;
      drain_cyc_q <= '0;
    end else begin
      if (state_q == Flush && flush_ready_i) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (state_q == Drain) drain_cyc_q <= drain_cyc_q + 32'd1;
    end
  end

  assign flush_cnt_o = flush_cnt_q;
  assign drain_cyc_o = drain_cyc_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_snitch_ro_cache_ctrl.sv
// Randomised scoreboard bench for snitch_ro_cache_ctrl: expected acks/config results are queued
// when stimulus is issued and a negedge monitor pops them whenever the DUT responds.
module tb_snitch_ro_cache_ctrl;
  localparam int unsigned NrReq       = 4;
  localparam int unsigned NrAddrRules = 1;
  localparam int unsigned AW          = 48;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NrReq-1:0]  flush_req, flush_ack;
  logic              cfg_valid, cfg_ready, cfg_enable, cfg_flush;
  logic              cfg_rule;
  logic [AW-1:0]     cfg_start, cfg_end;
  logic              ar_hs, rlast_hs, enable, flush_valid, flush_ready, busy;
  logic [AW-1:0]     start_addr, end_addr;

  always #5 clk_i = ~clk_i;

  snitch_ro_cache_ctrl #(.NrReq(NrReq), .NrAddrRules(NrAddrRules), .AxiAddrWidth(AW),
                         .MaxTrans(8), .EnableRst(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .flush_req_i(flush_req), .flush_ack_o(flush_ack),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_rule_i(cfg_rule),
    .cfg_start_i(cfg_start), .cfg_end_i(cfg_end), .cfg_enable_i(cfg_enable),
    .cfg_flush_i(cfg_flush), .cache_ar_hs_i(ar_hs), .cache_rlast_hs_i(rlast_hs),
    .enable_o(enable), .start_addr_o(start_addr), .end_addr_o(end_addr),
    .flush_valid_o(flush_valid), .flush_ready_i(flush_ready), .busy_o(busy)
  );

  typedef struct packed { logic [AW-1:0] s; logic [AW-1:0] e; } rules_t;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  ack_exp[$];
  rules_t      cfg_exp[$];
  logic [AW-1:0] m_start, m_end;
  logic        m_en;
  int          bench_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT acks or accepts a config write.
  rules_t cur;
  bit     chk_cfg = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk_cfg = 1'b0;
    end else begin
      if (chk_cfg) begin
        check("rule_start", 64'(start_addr), 64'(cur.s));
        check("rule_end", 64'(end_addr), 64'(cur.e));
        chk_cfg = 1'b0;
      end
      if (flush_ack != '0) begin
        if (ack_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got %b expected none at %0t", flush_ack, $time);
        end else begin
          check("flush_ack", 64'(flush_ack), 64'(ack_exp.pop_front()));
        end
      end
      if (cfg_ready) begin
        if (cfg_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cfg_ready: got 1 expected 0 at %0t", $time);
        end else begin
          cur = cfg_exp.pop_front();
          chk_cfg = 1'b1;
        end
      end
    end
  end

  // Plays requester/cache/flush-port until the round is over; returns observed flush handshakes.
  task automatic service(input logic [3:0] late, output int nfl);
    int cyc = 0;
    bit seen = 1'b0;
    bit done = 1'b0;
    nfl = 0;
    while (!done && cyc < 400) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) flush_req = flush_req | late;
      if (busy) begin
        seen = 1'b1;
        check("enable_off_busy", 64'(enable), 64'(0));
      end
      if (flush_valid || cfg_ready) check("drained", 64'(bench_cnt), 64'(0));
      flush_req = flush_req & ~flush_ack;
      if (cfg_ready) cfg_valid = 1'b0;
      if (bench_cnt > 0 && $urandom_range(1, 0) == 1) begin
        rlast_hs = 1'b1;
        bench_cnt--;
      end else begin
        rlast_hs = 1'b0;
      end
      flush_ready = ($urandom_range(3, 0) != 0);
      if (flush_valid && flush_ready) nfl++;
      if (seen && !busy && flush_req == '0 && !cfg_valid) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL round_timeout: got busy=%0b expected round end", busy);
    end
    rlast_hs = 1'b0;
  endtask

  task automatic run_round(input logic [3:0] mask, input logic [3:0] late, input bit cv,
                           input logic rule, input logic [AW-1:0] s, input logic [AW-1:0] e,
                           input bit en, input bit fl, input int k);
    int nfl;
    int expf;
    for (int i = 0; i < k; i++) begin
      @(negedge clk_i);
      ar_hs = 1'b1;
      bench_cnt++;
    end
    @(negedge clk_i);
    ar_hs      = 1'b0;
    flush_req  = mask;
    cfg_valid  = cv;
    cfg_rule   = rule;
    cfg_start  = s;
    cfg_end    = e;
    cfg_enable = en;
    cfg_flush  = fl;
    if (cv) begin
      if (32'(rule) < NrAddrRules) begin
        m_start = s;
        m_end   = e;
      end
      m_en = en;
      cfg_exp.push_back('{s: m_start, e: m_end});
    end
    if ((mask | late) != '0) ack_exp.push_back(mask | late);
    expf = ((mask | late) != '0 || (cv && fl)) ? 1 : 0;
    service(late, nfl);
    check("flush_count", 64'(nfl), 64'(expf));
    check("enable_idle", 64'(enable), 64'(m_en));
    check("start_idle", 64'(start_addr), 64'(m_start));
    check("end_idle", 64'(end_addr), 64'(m_end));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int nfl;
    rst_i = 1'b1; flush_req = '0; cfg_valid = 1'b0; cfg_rule = 1'b0; cfg_start = '0;
    cfg_end = '0; cfg_enable = 1'b0; cfg_flush = 1'b0; ar_hs = 1'b0; rlast_hs = 1'b0;
    flush_ready = 1'b1; m_start = '0; m_end = '0; m_en = 1'b0; bench_cnt = 0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_flush_valid", 64'(flush_valid), 64'(0));
    check("rst_ack", 64'(flush_ack), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    check("rst_enable", 64'(enable), 64'(0));
    check("rst_start", 64'(start_addr), 64'(0));
    rst_i = 1'b0;

    // Single-requester flush latency.
    @(negedge clk_i);
    flush_req = 4'b0001;
    ack_exp.push_back(4'b0001);
    @(negedge clk_i);
    check("t1_drain_busy", 64'(busy), 64'(1));
    check("t1_flush_valid_early", 64'(flush_valid), 64'(0));
    @(negedge clk_i);
    check("t1_flush_valid", 64'(flush_valid), 64'(1));
    @(negedge clk_i);
    check("t1_ack_cycle", 64'(flush_ack), 64'(4'b0001));
    flush_req = '0;
    @(negedge clk_i);
    check("t1_idle", 64'(busy), 64'(0));
    check("t1_enable", 64'(enable), 64'(m_en));

    // Config only: rule 0, enable on, no flush.
    run_round(4'b0000, 4'b0000, 1'b1, 1'b0, 48'h0000_8000_0000, 48'h0000_9000_0000, 1'b1, 1'b0, 0);
    check("t4_enable_on", 64'(enable), 64'(1));

    // Flush behind three outstanding reads.
    run_round(4'b0100, 4'b0000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 3);

    // Late requester joins the round during DRAIN.
    run_round(4'b0001, 4'b1000, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 0);

    // Simultaneous AR and RLAST at count 1 must keep DRAIN going.
    @(negedge clk_i);
    ar_hs = 1'b1;
    bench_cnt++;
    @(negedge clk_i);
    ar_hs = 1'b0;
    flush_req = 4'b0100;
    ack_exp.push_back(4'b0100);
    @(negedge clk_i);
    ar_hs = 1'b1;
    rlast_hs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("t6_still_drain", 64'(busy), 64'(1));
      check("t6_no_flush", 64'(flush_valid), 64'(0));
    end
    ar_hs = 1'b0;
    bench_cnt--;
    service(4'b0000, nfl);
    check("t6_flush_count", 64'(nfl), 64'(1));

    // Randomised rounds.
    for (int r = 0; r < 30; r++) begin
      logic [3:0] mask, late;
      bit cv;
      mask = 4'($urandom_range(15, 0));
      late = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'b0000;
      cv   = 1'($urandom_range(1, 0));
      if (mask == '0 && late == '0) cv = 1'b1;
      run_round(mask, late, cv, 1'($urandom_range(3, 0) == 0),
                {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)));
    end

    // Reset while a flush is stalled.
    @(negedge clk_i);
    flush_req = 4'b0001;
    flush_ready = 1'b0;
    repeat (10) @(negedge clk_i);
    check("t5_stalled_valid", 64'(flush_valid), 64'(1));
    rst_i = 1'b1;
    flush_req = '0;
    @(negedge clk_i);
    m_start = '0; m_end = '0; m_en = 1'b0; bench_cnt = 0;
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_flush_valid", 64'(flush_valid), 64'(0));
    check("t5_ack", 64'(flush_ack), 64'(0));
    check("t5_cfg_ready", 64'(cfg_ready), 64'(0));
    check("t5_enable", 64'(enable), 64'(0));
    check("t5_start", 64'(start_addr), 64'(0));
    check("t5_end", 64'(end_addr), 64'(0));
    rst_i = 1'b0;
    flush_ready = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("t5_no_ack", 64'(flush_ack), 64'(0));
    end
    run_round(4'b0010, 4'b0000, 1'b1, 1'b0, 48'h1234_5678_9abc, 48'h2234_5678_9abc, 1'b1, 1'b1, 2);

    check("ack_queue_empty", 64'(ack_exp.size()), 64'(0));
    check("cfg_queue_empty", 64'(cfg_exp.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
